// File: rtl/seq_mul_n_if.sv
// Request/response bundle for the sequential multiplier: operands and mode in,
// product and busy/fin handshake out.
interface seq_mul_n_if #(
    parameter int W = 8
);
    logic           start;
    logic           sgn;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] O;
    logic           busy;
    logic           fin;

    modport master (
        output start, sgn, A, B,
        input  O, busy, fin
    );

    modport slave (
        input  start, sgn, A, B,
        output O, busy, fin
    );
endinterface

// File: rtl/seq_mul_n.sv
// Multi-cycle shift-add multiplier, W x W -> 2W, unsigned or two's-complement.
// Works on operand magnitudes MSB-first and applies the sign at the end.
module seq_mul_n #(
    parameter int W = 8
) (
    input logic        ck,
    input logic        rst,
    seq_mul_n_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   ma;
    logic [W-1:0]   mb;
    logic           neg;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] prod;
    logic           busy_q;
    logic           fin_q;

    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] addend;

    // The magnitude of the most negative value still fits W bits unsigned.
    assign a_mag  = (bus.sgn && bus.A[W-1]) ? ((~bus.A) + W'(1)) : bus.A;
    assign b_mag  = (bus.sgn && bus.B[W-1]) ? ((~bus.B) + W'(1)) : bus.B;
    assign addend = mb[cnt] ? {{W{1'b0}}, ma} : '0;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ma     <= '0;
            mb     <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            prod   <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ma     <= a_mag;
                        mb     <= b_mag;
                        neg    <= bus.sgn & (bus.A[W-1] ^ bus.B[W-1]);
                        acc    <= '0;
                        cnt    <= CW'(W - 1);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= (acc << 1) + addend;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    prod   <= neg ? ((~acc) + {{(2*W-1){1'b0}}, 1'b1}) : acc;
                    fin_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O    = prod;
    assign bus.busy = busy_q;
    assign bus.fin  = fin_q;
endmodule

// File: tb/tb_seq_mul_n.sv
// Directed self-checking bench for seq_mul_n with a W=8 and a W=16 instance
// sharing clock and reset.
module tb_seq_mul_n;
    logic ck;
    logic rst;
    int   checks;
    int   errors;

    seq_mul_n_if #(.W(8))  bus8();
    seq_mul_n_if #(.W(16)) bus16();

    seq_mul_n #(.W(8))  dut8  (.ck(ck), .rst(rst), .bus(bus8));
    seq_mul_n #(.W(16)) dut16 (.ck(ck), .rst(rst), .bus(bus16));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Pulse start for one edge, then wait (bounded) for fin; lat counts edges after acceptance.
    task automatic do_op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output int lat);
        @(negedge ck);
        bus8.start = 1'b1; bus8.sgn = s; bus8.A = a; bus8.B = b;
        @(posedge ck);
        @(negedge ck);
        bus8.start = 1'b0;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge ck);
            @(negedge ck);
            if (bus8.fin) begin
                lat = i;
                res = bus8.O;
                break;
            end
        end
    endtask

    task automatic do_op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] res, output int lat);
        @(negedge ck);
        bus16.start = 1'b1; bus16.sgn = s; bus16.A = a; bus16.B = b;
        @(posedge ck);
        @(negedge ck);
        bus16.start = 1'b0;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge ck);
            @(negedge ck);
            if (bus16.fin) begin
                lat = i;
                res = bus16.O;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.sgn = 1'b0; bus8.A = '0; bus8.B = '0;
        bus16.start = 1'b0; bus16.sgn = 1'b0; bus16.A = '0; bus16.B = '0;
        #3;
        checks++;
        if (bus8.O !== 16'h0000 || bus8.busy !== 1'b0 || bus8.fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset8 O=%h busy=%b fin=%b expected 0/0/0", bus8.O, bus8.busy, bus8.fin);
        end
        checks++;
        if (bus16.O !== 32'h0 || bus16.busy !== 1'b0 || bus16.fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset16 O=%h busy=%b fin=%b expected 0/0/0", bus16.O, bus16.busy, bus16.fin);
        end
        repeat (2) @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max;
        int busy_err;
        int fin_err;
        busy_err = 0;
        fin_err = 0;
        @(negedge ck);
        bus8.start = 1'b1; bus8.sgn = 1'b0; bus8.A = 8'hFF; bus8.B = 8'hFF;
        @(posedge ck);
        @(negedge ck);
        bus8.start = 1'b0;
        checks++;
        if (bus8.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_accept busy=%b expected 1", bus8.busy);
        end
        for (int n = 1; n <= 10; n++) begin
            @(posedge ck);
            @(negedge ck);
            if (n <= 8 && (bus8.busy !== 1'b1 || bus8.fin !== 1'b0)) busy_err++;
            if (n == 9) begin
                checks++;
                if (bus8.fin !== 1'b1 || bus8.busy !== 1'b0 || bus8.O !== 16'hFE01) begin
                    errors++;
                    $display("[TB] FAIL ffxff_done fin=%b busy=%b O=%h expected 1/0/fe01", bus8.fin, bus8.busy, bus8.O);
                end
            end
            if (n == 10 && bus8.fin !== 1'b0) fin_err++;
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("[TB] FAIL ffxff_run_busy bad_cycles=%0d expected 0", busy_err);
        end
        checks++;
        if (fin_err != 0) begin
            errors++;
            $display("[TB] FAIL ffxff_fin_width fin still high got %0d expected 0", fin_err);
        end
        repeat (10) @(negedge ck);
        checks++;
        if (bus8.O !== 16'hFE01) begin
            errors++;
            $display("[TB] FAIL ffxff_hold O=%h expected fe01", bus8.O);
        end
    endtask

    task automatic test_modes;
        logic [15:0] res;
        int lat;
        do_op8(1'b1, 8'hFD, 8'h05, res, lat);
        checks++;
        if (res !== 16'hFFF1 || lat != 9) begin
            errors++;
            $display("[TB] FAIL signed_m3x5 O=%h lat=%0d expected fff1 lat 9", res, lat);
        end
        do_op8(1'b1, 8'h80, 8'h80, res, lat);
        checks++;
        if (res !== 16'h4000 || lat != 9) begin
            errors++;
            $display("[TB] FAIL signed_min_sq O=%h lat=%0d expected 4000 lat 9", res, lat);
        end
        do_op8(1'b1, 8'h80, 8'h7F, res, lat);
        checks++;
        if (res !== 16'hC080 || lat != 9) begin
            errors++;
            $display("[TB] FAIL signed_min_max O=%h lat=%0d expected c080 lat 9", res, lat);
        end
        do_op8(1'b0, 8'hFD, 8'h05, res, lat);
        checks++;
        if (res !== 16'h04F1 || lat != 9) begin
            errors++;
            $display("[TB] FAIL unsigned_fdx5 O=%h lat=%0d expected 04f1 lat 9", res, lat);
        end
        do_op8(1'b0, 8'h00, 8'hAB, res, lat);
        checks++;
        if (res !== 16'h0000 || lat != 9) begin
            errors++;
            $display("[TB] FAIL zero_operand O=%h lat=%0d expected 0000 lat 9", res, lat);
        end
    endtask

    task automatic test_start_busy;
        int fins;
        int fin_n;
        logic [15:0] fin_o;
        fins = 0;
        fin_n = -1;
        fin_o = '0;
        @(negedge ck);
        bus8.start = 1'b1; bus8.sgn = 1'b0; bus8.A = 8'd3; bus8.B = 8'd4;
        @(posedge ck);
        @(negedge ck);
        bus8.start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge ck);
            @(negedge ck);
            if (bus8.fin) begin
                fins++;
                if (fin_n < 0) begin
                    fin_n = n;
                    fin_o = bus8.O;
                end
            end
            if (n == 12) begin
                checks++;
                if (bus8.busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL busy_ignored_restart busy=%b expected 0", bus8.busy);
                end
            end
            if (n == 2) begin
                bus8.start = 1'b1; bus8.A = 8'd9; bus8.B = 8'd9;
            end
            if (n >= 3 && n <= 7) begin
                bus8.A = 8'(n * 37); bus8.B = 8'(~n); bus8.sgn = n[0];
            end
            if (n == 8) begin
                bus8.start = 1'b0; bus8.sgn = 1'b0;
            end
        end
        checks++;
        if (fins != 1 || fin_n != 9 || fin_o !== 16'h000C) begin
            errors++;
            $display("[TB] FAIL start_while_busy fins=%0d at=%0d O=%h expected 1 at 9 O=000c", fins, fin_n, fin_o);
        end
    endtask

    task automatic test_back_to_back;
        int fins;
        int t0, t1;
        logic [15:0] o0, o1;
        int lowcnt;
        fins = 0; t0 = -1; t1 = -1; o0 = '0; o1 = '0; lowcnt = 0;
        @(negedge ck);
        bus8.start = 1'b1; bus8.sgn = 1'b0; bus8.A = 8'd2; bus8.B = 8'd3;
        @(posedge ck);
        @(negedge ck);
        bus8.A = 8'd5; bus8.B = 8'd7;
        for (int n = 1; n <= 25; n++) begin
            @(posedge ck);
            @(negedge ck);
            if (bus8.fin) begin
                if (fins == 0) begin t0 = n; o0 = bus8.O; end
                if (fins == 1) begin t1 = n; o1 = bus8.O; end
                fins++;
            end
            if (n <= 18 && bus8.busy !== 1'b1) lowcnt++;
            if (n == 10) bus8.start = 1'b0;
        end
        checks++;
        if (fins != 2 || t0 != 9 || o0 !== 16'd6) begin
            errors++;
            $display("[TB] FAIL b2b_first fins=%0d at=%0d O=%0d expected 2 fins, at 9, O=6", fins, t0, o0);
        end
        checks++;
        if (t1 != 19 || o1 !== 16'd35) begin
            errors++;
            $display("[TB] FAIL b2b_second at=%0d O=%0d expected at 19, O=35", t1, o1);
        end
        checks++;
        if (lowcnt != 1) begin
            errors++;
            $display("[TB] FAIL b2b_busy_gap low_cycles=%0d expected 1", lowcnt);
        end
    endtask

    task automatic test_reset_mid;
        int fins;
        logic [15:0] res;
        int lat;
        fins = 0;
        @(negedge ck);
        bus8.start = 1'b1; bus8.sgn = 1'b0; bus8.A = 8'd5; bus8.B = 8'd5;
        @(posedge ck);
        @(negedge ck);
        bus8.start = 1'b0;
        repeat (4) begin
            @(posedge ck);
            @(negedge ck);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus8.O !== 16'h0000 || bus8.busy !== 1'b0 || bus8.fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset O=%h busy=%b fin=%b expected 0/0/0", bus8.O, bus8.busy, bus8.fin);
        end
        @(negedge ck);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge ck);
            if (bus8.fin) fins++;
        end
        checks++;
        if (fins != 0) begin
            errors++;
            $display("[TB] FAIL abandoned_op fins=%0d expected 0", fins);
        end
        do_op8(1'b0, 8'd7, 8'd6, res, lat);
        checks++;
        if (res !== 16'd42 || lat != 9) begin
            errors++;
            $display("[TB] FAIL after_reset O=%0d lat=%0d expected 42 lat 9", res, lat);
        end
    endtask

    task automatic test_w16;
        logic [31:0] res;
        int lat;
        do_op16(1'b0, 16'hFFFF, 16'hFFFF, res, lat);
        checks++;
        if (res !== 32'hFFFE0001 || lat != 17) begin
            errors++;
            $display("[TB] FAIL w16_unsigned O=%h lat=%0d expected fffe0001 lat 17", res, lat);
        end
        do_op16(1'b1, 16'h8000, 16'h0001, res, lat);
        checks++;
        if (res !== 32'hFFFF8000 || lat != 17) begin
            errors++;
            $display("[TB] FAIL w16_signed O=%h lat=%0d expected ffff8000 lat 17", res, lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned_max();
        test_modes();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_mul_n.md
Name: seq_mul_n

Overview:
- Parametrised multi-cycle shift-add multiplier: W-bit x W-bit, full 2W-bit product.
- Per-operation unsigned or two's-complement signed mode.
- Explicit busy/fin handshake; result register holds its value until the next completion.
- Next-generation sequential arithmetic unit for the datapath; feeds accumulator/ALU stages that wait on fin.

Parameters:
W, 8, operand width in bits (legal range 2..32); product width is 2W.

Ports:
ck  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled on rising ck, honoured only in IDLE
sgn  input  1  mode, sampled with start: 0 = unsigned, 1 = two's-complement signed
A  input  W  multiplicand, sampled with start
B  input  W  multiplier, sampled with start
O  output  2W  product register
busy  output  1  high while an operation is in progress
fin  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1): state=IDLE, O=0, busy=0, fin=0, internal operand/accumulator/counter registers cleared. Reset mid-operation abandons the operation; no fin is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch magnitudes ma=|A|, mb=|B|, each W bits unsigned. If sgn=0, ma=A and mb=B.
  - neg = sgn & (A[W-1] ^ B[W-1]).
  - acc=0, cnt=W-1, busy=1, go to RUN.
- IDLE, start=0: hold; fin=0.
- Magnitude of -2^(W-1) is 2^(W-1) and fits in W bits unsigned; no overflow case exists.
- RUN, one multiplier bit per edge, MSB first:
  - acc <= (acc<<1) + (mb[cnt] ? ma : 0), with acc 2W bits wide.
  - If cnt==0, go to DONE; otherwise cnt <= cnt-1.
  - Edges E1..EW process all W bits.
- DONE, edge E(W+1):
  - O <= neg ? (~acc+1) : acc, 2W-bit two's complement.
  - fin <= 1, busy <= 0, go to IDLE.
- fin is high for exactly one cycle, from E(W+1) to E(W+2). It is cleared on the next edge regardless of start.
- Latency: result valid and fin high W+1 edges after the accepting edge.
  - Minimum issue interval is W+2 cycles: start is accepted again at E(W+2), in the same cycle fin is high.
  - start may be held high continuously; it is re-accepted at each IDLE edge.
- start while busy (RUN or DONE): ignored. No restart, no queueing, operands unaffected.
- A, B and sgn changes after the accepting edge have no effect on the result in flight.
- O holds its last result through IDLE and the next RUN; it changes only at a DONE edge or on reset.
- Zero operands take the full latency; there is no early termination.
- Unsigned result range: 0..(2^W-1)^2. Signed result range: -2^(2W-2)+2^(W-1) .. 2^(2W-2). Both fit 2W bits exactly.

Test Plan:
- W=8, sgn=0, A=0xFF, B=0xFF, start pulse at E0 -> busy high E0..E9; fin=1 only in cycle after E9; O=0xFE01; O still 0xFE01 ten cycles later.
- W=8, sgn=1:
  - A=0xFD (-3), B=0x05 -> O=0xFFF1 (-15).
  - A=0x80, B=0x80 -> O=0x4000.
  - A=0x80, B=0x7F -> O=0xC080.
  - sgn=0 with A=0xFD, B=0x05 -> O=0x04F1.
- Start while busy, W=8: start A=3,B=4, then assert start at E3 with A=9,B=9 -> single fin at E9 with O=0x000C; no second fin. Operand inputs toggled during RUN do not change the result.
- Back-to-back, W=8: start held high continuously with A=2,B=3 then A=5,B=7 -> fin pulses at E9 (O=6) and E19 (O=35); busy low for exactly one cycle between operations.
- Reset: rst asserted asynchronously mid-RUN (between E4 and E5) -> O, busy, fin go 0 immediately without a clock edge. After release, a new start A=7,B=6 gives O=42 at E9 relative to its own accepting edge.
- W=16 instance: sgn=0, A=B=0xFFFF -> O=0xFFFE0001 with fin at E17. sgn=1, A=0x8000, B=0x0001 -> O=0xFFFF8000.
